// File: rtl/wb_aperture_ctrl_pkg.sv
// Shared types, slave indices and aperture decode helper for the Wishbone
// aperture controller.
package wb_aperture_ctrl_pkg;

  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned EVT_CNT_WIDTH = 8;
  localparam int unsigned NUM_SLAVES    = 3;

  localparam int unsigned SLV_FPGA_REG = 0;
  localparam int unsigned SLV_UART0    = 1;
  localparam int unsigned SLV_QL_RSVD  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic                  ack;
    logic [DATA_WIDTH-1:0] dat;
  } wb_rsp_t;

  // True when adr and base agree on bits [msb:lsb].
  function automatic logic addr_hit(input logic [31:0] adr,
                                    input logic [31:0] base,
                                    input int unsigned lsb,
                                    input int unsigned msb);
    logic [31:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      mask[i] = (i >= lsb) && (i <= msb);
    end
    return ((adr ^ base) & mask) == 32'd0;
  endfunction

endpackage

// File: rtl/wb_timeout_cntr.sv
// Per-access cycle counter with terminal-count flag, plus a saturating
// count of timeout events for debug.
module wb_timeout_cntr
  import wb_aperture_ctrl_pkg::*;
#(
  parameter int unsigned CNTR_WIDTH   = 3,
  parameter int unsigned CNTR_TIMEOUT = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cnt_run,
  output logic                     tc_c,
  input  logic                     evt,
  input  logic                     evt_clr,
  output logic [EVT_CNT_WIDTH-1:0] evt_cnt
);

  logic [CNTR_WIDTH-1:0] cnt;

  // Counts while an access is outstanding, otherwise parks at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt_run) begin
      cnt <= cnt + CNTR_WIDTH'(1);
    end else begin
      cnt <= '0;
    end
  end

  assign tc_c = (cnt == CNTR_WIDTH'(CNTR_TIMEOUT));

  // Clear takes priority over a coincident event.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_cnt <= '0;
    end else if (evt_clr) begin
      evt_cnt <= '0;
    end else if (evt && (evt_cnt != {EVT_CNT_WIDTH{1'b1}})) begin
      evt_cnt <= evt_cnt + EVT_CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/wb_aperture_ctrl.sv
// Wishbone slave-side aperture decoder with ack forwarding and a bounded
// timeout that answers unmapped or hung accesses with a default response.
module wb_aperture_ctrl
  import wb_aperture_ctrl_pkg::*;
#(
  parameter int unsigned          APERWIDTH                = 17,
  parameter int unsigned          APERSIZE                 = 10,
  parameter logic [APERWIDTH-1:0] FPGA_REG_BASE_ADDRESS    = 17'h00000,
  parameter logic [APERWIDTH-1:0] UART0_BASE_ADDRESS       = 17'h01000,
  parameter logic [APERWIDTH-1:0] QL_RESERVED_BASE_ADDRESS = 17'h03000,
  parameter logic [31:0]          DEFAULT_READ_VALUE       = 32'hBAD_FAB_AC,
  parameter int unsigned          DEFAULT_CNTR_WIDTH       = 3,
  parameter int unsigned          DEFAULT_CNTR_TIMEOUT     = 7
) (
  input  logic                  WB_CLK,
  input  logic                  WB_RST,
  input  logic [APERWIDTH-1:0]  WBs_ADR,
  input  logic                  WBs_CYC,
  input  logic                  WBs_STB,
  output logic                  WBs_ACK,
  output logic [DATA_WIDTH-1:0] WBs_RD_DAT,
  output logic                  FPGA_REG_CYC_o,
  output logic                  UART0_CYC_o,
  output logic                  QL_RESERVED_CYC_o,
  input  logic                  FPGA_REG_ACK_i,
  input  logic                  UART0_ACK_i,
  input  logic                  QL_RESERVED_ACK_i,
  input  logic [DATA_WIDTH-1:0] FPGA_REG_RD_DAT_i,
  input  logic [DATA_WIDTH-1:0] UART0_RD_DAT_i,
  input  logic [DATA_WIDTH-1:0] QL_RESERVED_RD_DAT_i,
  input  logic                  Timeout_Cnt_Clr_i,
  output logic                  Timeout_Pulse_o,
  output logic [7:0]            Timeout_Cnt_o
);

  wb_state_e             state;
  logic                  to_ack_q;
  logic [NUM_SLAVES-1:0] hit_c;
  wb_rsp_t               rsp [NUM_SLAVES];
  logic                  sel_ack_c;
  logic [DATA_WIDTH-1:0] sel_dat_c;
  logic                  start_c;
  logic                  tc_c;
  logic                  cnt_run_c;
  logic                  timeout_evt_c;
  logic                  slave_ack_c;
  logic                  def_ack_c;
  logic                  cyc_gate_c;

  // Aperture decode and selected-slave response mux.
  always_comb begin
    hit_c = '0;
    hit_c[SLV_FPGA_REG] = addr_hit(32'(WBs_ADR), 32'(FPGA_REG_BASE_ADDRESS),
                                   APERSIZE + 2, APERWIDTH - 1);
    hit_c[SLV_UART0]    = addr_hit(32'(WBs_ADR), 32'(UART0_BASE_ADDRESS),
                                   APERSIZE + 2, APERWIDTH - 1);
    hit_c[SLV_QL_RSVD]  = addr_hit(32'(WBs_ADR), 32'(QL_RESERVED_BASE_ADDRESS),
                                   APERSIZE + 2, APERWIDTH - 1);

    rsp[SLV_FPGA_REG] = '{ack: FPGA_REG_ACK_i,    dat: FPGA_REG_RD_DAT_i};
    rsp[SLV_UART0]    = '{ack: UART0_ACK_i,       dat: UART0_RD_DAT_i};
    rsp[SLV_QL_RSVD]  = '{ack: QL_RESERVED_ACK_i, dat: QL_RESERVED_RD_DAT_i};

    sel_ack_c = 1'b0;
    sel_dat_c = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (hit_c[i]) begin
        sel_ack_c = sel_ack_c | rsp[i].ack;
        sel_dat_c = sel_dat_c | rsp[i].dat;
      end
    end
  end

  // Control terms; a slave ack on the terminal cycle suppresses the timeout.
  always_comb begin
    start_c       = WBs_CYC && WBs_STB;
    cnt_run_c     = ((state == ST_IDLE) && start_c) ||
                    ((state == ST_ACTIVE) && WBs_CYC && !sel_ack_c && !tc_c);
    timeout_evt_c = (state == ST_ACTIVE) && WBs_CYC && tc_c && !sel_ack_c;
  end

  wb_timeout_cntr #(
    .CNTR_WIDTH  (DEFAULT_CNTR_WIDTH),
    .CNTR_TIMEOUT(DEFAULT_CNTR_TIMEOUT)
  ) u_timeout_cntr (
    .clk    (WB_CLK),
    .rst    (WB_RST),
    .cnt_run(cnt_run_c),
    .tc_c   (tc_c),
    .evt    (timeout_evt_c),
    .evt_clr(Timeout_Cnt_Clr_i),
    .evt_cnt(Timeout_Cnt_o)
  );

  // Access FSM; DONE holds until the master releases the cycle.
  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      state    <= ST_IDLE;
      to_ack_q <= 1'b0;
    end else begin
      to_ack_q <= timeout_evt_c;
      case (state)
        ST_IDLE: begin
          if (start_c) state <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (!WBs_CYC)                 state <= ST_IDLE;
          else if (sel_ack_c || tc_c)   state <= ST_DONE;
        end
        ST_DONE: begin
          if (!WBs_CYC || !WBs_STB)     state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Bus-facing outputs; everything is forced quiet while reset is held.
  always_comb begin
    cyc_gate_c        = WBs_CYC && !WB_RST && (state != ST_DONE);
    FPGA_REG_CYC_o    = cyc_gate_c && hit_c[SLV_FPGA_REG];
    UART0_CYC_o       = cyc_gate_c && hit_c[SLV_UART0];
    QL_RESERVED_CYC_o = cyc_gate_c && hit_c[SLV_QL_RSVD];

    slave_ack_c     = (state == ST_ACTIVE) && WBs_CYC && sel_ack_c && !WB_RST;
    def_ack_c       = to_ack_q && !WB_RST;
    WBs_ACK         = slave_ack_c || def_ack_c;
    Timeout_Pulse_o = def_ack_c;

    WBs_RD_DAT = '0;
    if (slave_ack_c)    WBs_RD_DAT = sel_dat_c;
    else if (def_ack_c) WBs_RD_DAT = DEFAULT_READ_VALUE;
  end

endmodule

// File: tb/tb_wb_aperture_ctrl.sv
// Directed bench for wb_aperture_ctrl: decode, slave ack forwarding, timeout,
// abort, saturation, clear priority and reset.
module tb_wb_aperture_ctrl;

  localparam logic [31:0] DEF_RD = 32'hBADFABAC;

  logic        WB_CLK;
  logic        WB_RST;
  logic [16:0] WBs_ADR;
  logic        WBs_CYC;
  logic        WBs_STB;
  logic        WBs_ACK;
  logic [31:0] WBs_RD_DAT;
  logic        FPGA_REG_CYC_o;
  logic        UART0_CYC_o;
  logic        QL_RESERVED_CYC_o;
  logic        FPGA_REG_ACK_i;
  logic        UART0_ACK_i;
  logic        QL_RESERVED_ACK_i;
  logic [31:0] FPGA_REG_RD_DAT_i;
  logic [31:0] UART0_RD_DAT_i;
  logic [31:0] QL_RESERVED_RD_DAT_i;
  logic        Timeout_Cnt_Clr_i;
  logic        Timeout_Pulse_o;
  logic [7:0]  Timeout_Cnt_o;

  int checks;
  int errors;

  wb_aperture_ctrl dut (
    .WB_CLK              (WB_CLK),
    .WB_RST              (WB_RST),
    .WBs_ADR             (WBs_ADR),
    .WBs_CYC             (WBs_CYC),
    .WBs_STB             (WBs_STB),
    .WBs_ACK             (WBs_ACK),
    .WBs_RD_DAT          (WBs_RD_DAT),
    .FPGA_REG_CYC_o      (FPGA_REG_CYC_o),
    .UART0_CYC_o         (UART0_CYC_o),
    .QL_RESERVED_CYC_o   (QL_RESERVED_CYC_o),
    .FPGA_REG_ACK_i      (FPGA_REG_ACK_i),
    .UART0_ACK_i         (UART0_ACK_i),
    .QL_RESERVED_ACK_i   (QL_RESERVED_ACK_i),
    .FPGA_REG_RD_DAT_i   (FPGA_REG_RD_DAT_i),
    .UART0_RD_DAT_i      (UART0_RD_DAT_i),
    .QL_RESERVED_RD_DAT_i(QL_RESERVED_RD_DAT_i),
    .Timeout_Cnt_Clr_i   (Timeout_Cnt_Clr_i),
    .Timeout_Pulse_o     (Timeout_Pulse_o),
    .Timeout_Cnt_o       (Timeout_Cnt_o)
  );

  initial WB_CLK = 1'b0;
  always #5 WB_CLK = ~WB_CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Move to the next cycle; inputs are driven just after the edge.
  task automatic tick();
    @(posedge WB_CLK);
    #1;
  endtask

  function automatic logic [31:0] cyc_vec();
    return 32'({FPGA_REG_CYC_o, UART0_CYC_o, QL_RESERVED_CYC_o});
  endfunction

  task automatic bus_start(input logic [16:0] adr);
    WBs_ADR = adr;
    WBs_CYC = 1'b1;
    WBs_STB = 1'b1;
  endtask

  task automatic bus_idle();
    WBs_CYC = 1'b0;
    WBs_STB = 1'b0;
  endtask

  // Access that no slave answers; default ack expected on cycle 8.
  task automatic timeout_access(input logic [16:0] adr, input logic [31:0] exp_cyc,
                                input logic [7:0] exp_cnt, input bit detail);
    bus_start(adr);
    #1;
    for (int c = 0; c < 8; c++) begin
      if (detail) begin
        check($sformatf("to_ack_c%0d", c), 32'(WBs_ACK), 32'd0);
        check($sformatf("to_cyc_c%0d", c), cyc_vec(), exp_cyc);
      end
      tick();
    end
    check("to_ack_c8", 32'(WBs_ACK), 32'd1);
    check("to_cnt_c8", 32'(Timeout_Cnt_o), 32'(exp_cnt));
    if (detail) begin
      check("to_dat_c8", WBs_RD_DAT, DEF_RD);
      check("to_pulse_c8", 32'(Timeout_Pulse_o), 32'd1);
      check("to_cyc_c8", cyc_vec(), 32'd0);
      tick();
      check("to_ack_c9", 32'(WBs_ACK), 32'd0);
      check("to_pulse_c9", 32'(Timeout_Pulse_o), 32'd0);
      check("to_dat_c9", WBs_RD_DAT, 32'd0);
    end
    bus_idle();
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    WB_RST = 1'b1;
    WBs_ADR = '0;
    bus_idle();
    FPGA_REG_ACK_i = 1'b0;
    UART0_ACK_i = 1'b0;
    QL_RESERVED_ACK_i = 1'b0;
    FPGA_REG_RD_DAT_i = 32'h11111111;
    UART0_RD_DAT_i = 32'h0;
    QL_RESERVED_RD_DAT_i = 32'h0;
    Timeout_Cnt_Clr_i = 1'b0;
    tick();
    tick();
    check("rst_ack", 32'(WBs_ACK), 32'd0);
    check("rst_dat", WBs_RD_DAT, 32'd0);
    check("rst_cyc", cyc_vec(), 32'd0);
    check("rst_pulse", 32'(Timeout_Pulse_o), 32'd0);
    check("rst_cnt", 32'(Timeout_Cnt_o), 32'd0);
    WB_RST = 1'b0;
    tick();

    // UART0 read acked on the second cycle.
    bus_start(17'h01010);
    UART0_RD_DAT_i = 32'h000000A5;
    #1;
    check("uart_cyc_c0", cyc_vec(), 32'b010);
    check("uart_ack_c0", 32'(WBs_ACK), 32'd0);
    check("uart_dat_c0", WBs_RD_DAT, 32'd0);
    tick();
    UART0_ACK_i = 1'b1;
    #1;
    check("uart_ack_c1", 32'(WBs_ACK), 32'd1);
    check("uart_dat_c1", WBs_RD_DAT, 32'h000000A5);
    check("uart_pulse_c1", 32'(Timeout_Pulse_o), 32'd0);
    tick();
    UART0_ACK_i = 1'b0;
    #1;
    check("uart_done_cyc", cyc_vec(), 32'd0);
    check("uart_done_ack", 32'(WBs_ACK), 32'd0);
    bus_idle();
    tick();
    check("uart_cnt", 32'(Timeout_Cnt_o), 32'd0);

    // Unmapped access, then register slave that never answers.
    timeout_access(17'h02000, 32'd0, 8'd1, 1'b1);
    timeout_access(17'h00004, 32'b100, 8'd2, 1'b1);

    // QL reserved acks exactly on the terminal-count cycle.
    bus_start(17'h03000);
    QL_RESERVED_RD_DAT_i = 32'h12345678;
    for (int c = 0; c < 7; c++) tick();
    QL_RESERVED_ACK_i = 1'b1;
    #1;
    check("tc_ack_c7", 32'(WBs_ACK), 32'd1);
    check("tc_dat_c7", WBs_RD_DAT, 32'h12345678);
    check("tc_cyc_c7", cyc_vec(), 32'b001);
    tick();
    QL_RESERVED_ACK_i = 1'b0;
    #1;
    check("tc_ack_c8", 32'(WBs_ACK), 32'd0);
    check("tc_pulse_c8", 32'(Timeout_Pulse_o), 32'd0);
    check("tc_cnt_c8", 32'(Timeout_Cnt_o), 32'd2);
    bus_idle();
    tick();

    // Master abort at cycle 3 of an unmapped access.
    bus_start(17'h02000);
    for (int c = 0; c < 3; c++) tick();
    WBs_CYC = 1'b0;
    #1;
    for (int c = 3; c < 11; c++) begin
      check($sformatf("abort_ack_c%0d", c), 32'(WBs_ACK), 32'd0);
      tick();
    end
    check("abort_cnt", 32'(Timeout_Cnt_o), 32'd2);
    bus_idle();
    tick();
    timeout_access(17'h02000, 32'd0, 8'd3, 1'b1);

    // Saturation of the timeout count.
    for (int n = 0; n < 300; n++) begin
      timeout_access(17'h1F000, 32'd0, (n < 252) ? 8'(4 + n) : 8'hFF, 1'b0);
    end
    check("sat_cnt", 32'(Timeout_Cnt_o), 32'hFF);

    // Clear coincident with a timeout event.
    bus_start(17'h02000);
    for (int c = 0; c < 7; c++) tick();
    Timeout_Cnt_Clr_i = 1'b1;
    tick();
    Timeout_Cnt_Clr_i = 1'b0;
    #1;
    check("clr_cnt", 32'(Timeout_Cnt_o), 32'd0);
    check("clr_ack", 32'(WBs_ACK), 32'd1);
    check("clr_pulse", 32'(Timeout_Pulse_o), 32'd1);
    bus_idle();
    tick();
    timeout_access(17'h02000, 32'd0, 8'd1, 1'b0);

    // Reset on the terminal cycle drops the pending default ack.
    bus_start(17'h00004);
    for (int c = 0; c < 7; c++) tick();
    WB_RST = 1'b1;
    tick();
    check("mrst_ack", 32'(WBs_ACK), 32'd0);
    check("mrst_dat", WBs_RD_DAT, 32'd0);
    check("mrst_cyc", cyc_vec(), 32'd0);
    check("mrst_pulse", 32'(Timeout_Pulse_o), 32'd0);
    check("mrst_cnt", 32'(Timeout_Cnt_o), 32'd0);
    WB_RST = 1'b0;
    bus_idle();
    tick();
    timeout_access(17'h02000, 32'd0, 8'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
